// File: rtl/mem_arb_pkg.sv
// Shared widths and FSM state encoding for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 48;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned NREQ   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to
// the requester that was not served last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] REQ,
  input  logic            LAST,
  output logic [NREQ-1:0] WIN
);

  always_comb begin
    WIN = '0;
    case (REQ)
      2'b01:   WIN = 2'b01;
      2'b10:   WIN = 2'b10;
      2'b11:   WIN = LAST ? 2'b01 : 2'b10;
      default: WIN = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: grants one requester, drives the memory
// controller until handshake or timeout, then returns data/status for one cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ*CTRL_W-1:0] REQ_CTRL,
  input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
  output logic [NREQ-1:0]        GNT,
  output logic [NREQ-1:0]        DONE,
  output logic [DATA_W-1:0]      RDATA,
  output logic                   ERR,
  output logic                   BUSY,
  output logic                   MC_ENABLE,
  output logic [CTRL_W-1:0]      MC_CTRL,
  output logic [ADDR_W-1:0]      MC_ADDRESS,
  input  logic                   MC_HANDSHAKE,
  input  logic [DATA_W-1:0]      MC_READ
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  state_t            state, state_nxt;
  logic              last;
  logic [NREQ-1:0]   win, win_q;
  logic [CNT_W-1:0]  cnt;
  logic              timeout_hit;

  rr_pick2 u_pick (
    .REQ  (REQ),
    .LAST (last),
    .WIN  (win)
  );

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    GNT       = win_q;
    MC_ENABLE = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      IDLE: begin
        GNT = '0;
        if (|REQ) state_nxt = ISSUE;
      end
      ISSUE: begin
        MC_ENABLE = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        MC_ENABLE = 1'b1;
        if (MC_HANDSHAKE || timeout_hit) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake is tested before timeout so a coincident handshake wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last       <= 1'b1;
      win_q      <= '0;
      MC_CTRL    <= '0;
      MC_ADDRESS <= '0;
      RDATA      <= '0;
      cnt        <= '0;
      DONE       <= '0;
      ERR        <= 1'b0;
    end else begin
      DONE <= '0;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (|REQ) begin
            win_q      <= win;
            last       <= win[1];
            MC_CTRL    <= win[1] ? REQ_CTRL[2*CTRL_W-1:CTRL_W] : REQ_CTRL[CTRL_W-1:0];
            MC_ADDRESS <= win[1] ? REQ_ADDR[2*ADDR_W-1:ADDR_W] : REQ_ADDR[ADDR_W-1:0];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (MC_HANDSHAKE) begin
            RDATA <= MC_READ;
            DONE  <= win_q;
          end else if (timeout_hit) begin
            RDATA <= '0;
            DONE  <= win_q;
            ERR   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
